stack_op_sequencer: RTL and testbench
=====================================

Name: stack_op_sequencer

Overview:
Sequences stack instructions onto a single-port synchronous-read stack RAM. It owns the stack pointer and full/empty status, and accepts one opcode at a time over a valid/ready handshake. It runs multi-cycle read/modify/write sequences (POP, DUP, SWAP, ...) and returns a one-cycle done pulse with the result. It sits between the push/pop I/O decode of the top-level stack design and the storage array, and generates the instructionDone indication.

Parameters:
DATA_W, 8, stack word width
DEPTH, 16, number of stack entries (power of 2, >= 2)
ADDR_W, $clog2(DEPTH), RAM address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
op_valid  in  1  instruction request
op_ready  out  1  high only in IDLE; an instruction is accepted on a rising edge where op_valid & op_ready
op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 PEEK, 4 DUP, 5 SWAP, 6 CLEAR, 7 reserved
op_data  in  DATA_W  PUSH operand; sampled at accept
done  out  1  one-cycle pulse, instruction complete
result  out  DATA_W  valid while done=1, else 0
err  out  1  one-cycle pulse with done, instruction rejected
count  out  ADDR_W+1  current number of entries
full  out  1  count == DEPTH
empty  out  1  count == 0
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write (valid with mem_en)
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (rst=1 at an edge): state IDLE, count=0, done=0, err=0, result=0. op_ready is 1 from the first cycle after reset. Reset aborts any in-flight sequence; stack contents are don't-care afterwards.
- Stack grows upward: the top is at address count-1. The next PUSH writes address count.
- mem_* are decoded from the state. Outside access cycles: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Cycle 0 is the accept cycle. op_code and op_data are latched at its closing edge. op_valid while busy is ignored; the requester holds its request.
- Sequences (cycle n = n cycles after accept):
  - NOP: done at c1.
  - CLEAR: count<=0, done at c1; no RAM access.
  - PUSH: c1 writes op_data to count; done at c2 with result=op_data.
  - POP: c1 reads count-1; done at c3 with result=rdata.
  - PEEK: same as POP; count unchanged.
  - DUP: c1 reads count-1; c2 writes rdata to count; done at c3 with result=top.
  - SWAP: c1 reads count-1; c2 latches A=rdata and reads count-2; c3 writes rdata (B) to count-1 and latches B; c4 writes A to count-2; done at c5 with result=B (the new top).
- count updates on the edge that closes the last RAM cycle. PUSH and DUP increment it; POP decrements it. The new value is visible in the done cycle. full and empty are derived from the count register.
- Error cases: PUSH when full; POP or PEEK when empty; DUP when empty or full; SWAP when count<2; opcode 7. In each case there is no RAM access and no count change; done=1, err=1 at c1, result=0.
- FSM states: IDLE, RD1, RD2, WR1, WR2, FIN.
  - FIN drives done/err/result and op_ready=0, then returns to IDLE.
  - Throughput: one instruction per latency+1 cycles.
- Arithmetic: count is ADDR_W+1 bits and never wraps, because error checks gate every increment and decrement.

Test Plan:
- Reset then 4 PUSHes (0x11,0x22,0x33,0x44) -> each done at c2 with result=operand; count=4; RAM[0..3]=11,22,33,44; empty=0.
- POP then PEEK -> POP result 0x44 at c3 and count=3; PEEK result 0x33 and count stays 3.
- SWAP with stack 11,22,33 -> done at c5, result=0x22; RAM[1]=0x33, RAM[2]=0x22; count=3. Then DUP -> result 0x22, RAM[3]=0x22, count=4.
- Fill to DEPTH=16 -> full=1; PUSH -> done+err at c1, no mem_en, count=16. CLEAR -> count=0; POP -> err; SWAP with count=1 -> err; opcode 7 -> err.
- Hold op_valid high through a SWAP -> op_ready=0 for c1..c5; the next op is accepted only after FIN, with no duplicate accept.
- Assert rst during SWAP c3 -> next cycle count=0, done=0, mem_en=0, op_ready=1; a following PUSH 0x55 -> result 0x55 and count=1.

Source files
------------

// File: rtl/stack_op_sequencer.sv
// Purpose: sequences stack instructions (PUSH/POP/PEEK/DUP/SWAP/CLEAR) onto a single-port sync-read RAM.
// Latency: done at c1 (NOP/CLEAR/error), c2 (PUSH), c3 (POP/PEEK/DUP), c5 (SWAP); one op per latency+1 cycles.
// Backpressure: op_ready is high only in IDLE; op_valid while busy is ignored and must be held by the requester.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   op_valid/op_ready/op_code/op_data   instruction handshake, opcode and PUSH operand
//   done/result/err               one-cycle completion pulse, result (0 when not done), reject flag
//   count/full/empty              stack occupancy status
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port (read data valid one cycle after the strobe)
module stack_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_WR1  = 3'd3;
    localparam logic [2:0] S_WR2  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_PEEK  = 3'd3;
    localparam logic [2:0] OP_DUP   = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;     // PUSH operand, popped/peeked/duplicated word, or SWAP word A
    logic [DATA_W-1:0] b_q, b_d;     // SWAP word B (the new top)
    logic              err_q, err_d;

    logic              is_full, is_empty, lt_two;
    logic [ADDR_W-1:0] addr_top, addr_below, addr_next;

    assign is_full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign is_empty = (count_q == '0);
    assign lt_two   = (count_q < (ADDR_W+1)'(2));

    // Low address bits are enough: an access at 'count' only happens when not full,
    // and accesses below the top only happen when enough entries exist.
    assign addr_next  = count_q[ADDR_W-1:0];
    assign addr_top   = count_q[ADDR_W-1:0] - ADDR_W'(1);
    assign addr_below = count_q[ADDR_W-1:0] - ADDR_W'(2);

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d  = op_code;
                    a_d   = op_data;
                    err_d = 1'b0;
                    case (op_code)
                        OP_NOP:   state_d = S_FIN;
                        OP_PUSH:  if (is_full) err_d = 1'b1; else state_d = S_WR1;
                        OP_POP,
                        OP_PEEK:  if (is_empty) err_d = 1'b1; else state_d = S_RD1;
                        OP_DUP:   if (is_empty || is_full) err_d = 1'b1; else state_d = S_RD1;
                        OP_SWAP:  if (lt_two) err_d = 1'b1; else state_d = S_RD1;
                        OP_CLEAR: begin
                            count_d = '0;
                            state_d = S_FIN;
                        end
                        default:  err_d = 1'b1;
                    endcase
                    // Rejected instructions skip all RAM cycles
                    if (err_d) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RD1: begin
                // POP's only RAM cycle is this read, so the decrement closes here
                if (op_q == OP_POP) begin
                    count_d = count_q - (ADDR_W+1)'(1);
                end
                state_d = (op_q == OP_DUP) ? S_WR1 : S_RD2;
            end
            S_RD2: begin
                // Top word arrives now: POP/PEEK result, or SWAP word A
                a_d     = mem_rdata;
                state_d = (op_q == OP_SWAP) ? S_WR1 : S_FIN;
            end
            S_WR1: begin
                if (op_q == OP_PUSH || op_q == OP_DUP) begin
                    count_d = count_q + (ADDR_W+1)'(1);
                end
                if (op_q == OP_DUP) begin
                    a_d = mem_rdata;
                end
                if (op_q == OP_SWAP) begin
                    b_d = mem_rdata;
                end
                state_d = (op_q == OP_SWAP) ? S_WR2 : S_FIN;
            end
            S_WR2:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM port decode, zero outside access cycles
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_RD1: begin
                mem_en   = 1'b1;
                mem_addr = addr_top;
            end
            S_RD2: begin
                if (op_q == OP_SWAP) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_below;
                end
            end
            S_WR1: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = (op_q == OP_SWAP) ? addr_top : addr_next;
                mem_wdata = (op_q == OP_PUSH) ? a_q : mem_rdata;
            end
            S_WR2: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_below;
                mem_wdata = a_q;
            end
            default: ;
        endcase
    end

    // Completion and status outputs
    always_comb begin
        done   = (state_q == S_FIN);
        err    = done & err_q;
        result = '0;
        if (done && !err_q) begin
            case (op_q)
                OP_PUSH, OP_POP, OP_PEEK, OP_DUP: result = a_q;
                OP_SWAP:                          result = b_q;
                default:                          result = '0;
            endcase
        end
    end

    assign op_ready = (state_q == S_IDLE);
    assign count    = count_q;
    assign full     = is_full;
    assign empty    = is_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Purpose: self-checking bench for stack_op_sequencer with a behavioural RAM and a queue-based stack model.
// Latency: checks done timing per opcode relative to the accept edge.
// Backpressure: checks op_ready deassertion while busy and single acceptance of a held request.
module tb_stack_op_sequencer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] op_data;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              err;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    stack_op_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_data(op_data),
        .done(done), .result(result), .err(err),
        .count(count), .full(full), .empty(empty),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read RAM
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int accepts = 0;
    always @(posedge clk) begin
        if (!rst && op_valid && op_ready) accepts <= accepts + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference stack: element 0 is the bottom
    logic [DATA_W-1:0] stk[$];

    task automatic model_step(input logic [2:0] op, input logic [DATA_W-1:0] d,
                              output logic [DATA_W-1:0] res, output bit e, output int lat);
        int n;
        logic [DATA_W-1:0] ta, tb;
        n   = stk.size();
        res = '0;
        e   = 1'b0;
        lat = 1;
        case (op)
            3'd0: lat = 1;
            3'd1: if (n == DEPTH) e = 1'b1; else begin stk.push_back(d); res = d; lat = 2; end
            3'd2: if (n == 0) e = 1'b1; else begin res = stk.pop_back(); lat = 3; end
            3'd3: if (n == 0) e = 1'b1; else begin res = stk[n-1]; lat = 3; end
            3'd4: if (n == 0 || n == DEPTH) e = 1'b1;
                  else begin res = stk[n-1]; stk.push_back(res); lat = 3; end
            3'd5: if (n < 2) e = 1'b1;
                  else begin
                      ta = stk[n-1]; tb = stk[n-2];
                      stk[n-1] = tb; stk[n-2] = ta;
                      res = tb; lat = 5;
                  end
            3'd6: stk.delete();
            default: e = 1'b1;
        endcase
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < stk.size(); i++) begin
            chk($sformatf("%s ram[%0d]", tag, i), ram[i], stk[i]);
        end
    endtask

    // Issue one instruction from IDLE and compare its completion against expectations
    task automatic run_op(input string tag, input logic [2:0] op, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] eres, input bit eerr, input int elat, input int ecnt);
        bit got, any_mem, stray;
        int lat;
        logic [DATA_W-1:0] r;
        logic e, f, em;
        logic [ADDR_W:0] c;
        got = 0; any_mem = 0; stray = 0; lat = 0;
        r = '0; e = 0; f = 0; em = 0; c = '0;
        @(negedge clk);
        chk({tag, " ready"}, op_ready, 1);
        op_valid = 1'b1; op_code = op; op_data = d;
        @(posedge clk);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (i == 1) op_valid = 1'b0;
            if (mem_en) any_mem = 1;
            if (done) begin
                got = 1; lat = i; r = result; e = err; c = count; f = full; em = empty;
            end else if (result != 0 || err) begin
                stray = 1;
            end
        end
        if (!got) chk({tag, " done timeout"}, 0, 1);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " result"}, r, eres);
        chk({tag, " err"}, e, eerr);
        chk({tag, " count"}, c, ecnt);
        chk({tag, " full"}, f, (ecnt == DEPTH));
        chk({tag, " empty"}, em, (ecnt == 0));
        chk({tag, " result/err outside done"}, stray, 0);
        if (eerr) chk({tag, " no mem access"}, any_mem, 0);
    endtask

    typedef struct {
        logic [2:0]        op;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] res;
        bit                err;
        int                lat;
        int                cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] op, logic [DATA_W-1:0] d, logic [DATA_W-1:0] res,
                                bit e, int lat, int cnt);
        vec_t v;
        v.op = op; v.d = d; v.res = res; v.err = e; v.lat = lat; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [DATA_W-1:0] mres, mres2;
        bit merr;
        int mlat, acc0, lat2;
        logic [2:0] rop;
        logic [DATA_W-1:0] rd;

        // Directed table
        tbl.push_back(mk(3'd1, 8'h11, 8'h11, 0, 2, 1));
        tbl.push_back(mk(3'd1, 8'h22, 8'h22, 0, 2, 2));
        tbl.push_back(mk(3'd1, 8'h33, 8'h33, 0, 2, 3));
        tbl.push_back(mk(3'd1, 8'h44, 8'h44, 0, 2, 4));
        tbl.push_back(mk(3'd2, 8'h00, 8'h44, 0, 3, 3));
        tbl.push_back(mk(3'd3, 8'h00, 8'h33, 0, 3, 3));
        tbl.push_back(mk(3'd5, 8'h00, 8'h22, 0, 5, 3));
        tbl.push_back(mk(3'd4, 8'h00, 8'h22, 0, 3, 4));
        for (int i = 5; i <= DEPTH; i++) tbl.push_back(mk(3'd1, 8'(8'h80 + i), 8'(8'h80 + i), 0, 2, i));
        tbl.push_back(mk(3'd1, 8'hEE, 8'h00, 1, 1, 16));
        tbl.push_back(mk(3'd4, 8'h00, 8'h00, 1, 1, 16));
        tbl.push_back(mk(3'd6, 8'h00, 8'h00, 0, 1, 0));
        tbl.push_back(mk(3'd2, 8'h00, 8'h00, 1, 1, 0));
        tbl.push_back(mk(3'd3, 8'h00, 8'h00, 1, 1, 0));
        tbl.push_back(mk(3'd4, 8'h00, 8'h00, 1, 1, 0));
        tbl.push_back(mk(3'd1, 8'h01, 8'h01, 0, 2, 1));
        tbl.push_back(mk(3'd5, 8'h00, 8'h00, 1, 1, 1));
        tbl.push_back(mk(3'd7, 8'h5A, 8'h00, 1, 1, 1));
        tbl.push_back(mk(3'd0, 8'h5A, 8'h00, 0, 1, 1));
        tbl.push_back(mk(3'd1, 8'h66, 8'h66, 0, 2, 2));

        rst = 1'b1; op_valid = 1'b0; op_code = '0; op_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset result", result, 0);
        chk("reset mem_en", mem_en, 0);
        chk("reset op_ready", op_ready, 1);

        foreach (tbl[k]) begin
            model_step(tbl[k].op, tbl[k].d, mres, merr, mlat);
            run_op($sformatf("vec%0d op%0d", k, tbl[k].op), tbl[k].op, tbl[k].d,
                   tbl[k].res, tbl[k].err, tbl[k].lat, tbl[k].cnt);
            check_ram($sformatf("vec%0d", k));
        end

        // Held request through a SWAP: one accept per instruction, ready low c1..c5
        acc0 = accepts;
        model_step(3'd5, 8'h00, mres, merr, mlat);
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd5; op_data = 8'h00;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold c%0d op_ready", i), op_ready, 0);
            if (i == 5) begin
                chk("hold first done", done, 1);
                chk("hold first result", result, mres);
            end
        end
        @(negedge clk);
        chk("hold c6 op_ready", op_ready, 1);
        model_step(3'd5, 8'h00, mres2, merr, mlat);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        lat2 = 0;
        for (int i = 2; i <= 8 && lat2 == 0; i++) begin
            @(negedge clk);
            if (done) begin
                lat2 = i;
                chk("hold second result", result, mres2);
            end
        end
        chk("hold second latency", lat2, 5);
        repeat (3) @(negedge clk);
        chk("hold accept count", accepts - acc0, 2);
        check_ram("hold");

        // Reset in SWAP c3
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd5; op_data = 8'h00;
        @(posedge clk);
        @(negedge clk); op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("abort count", count, 0);
        chk("abort done", done, 0);
        chk("abort mem_en", mem_en, 0);
        chk("abort op_ready", op_ready, 1);
        rst = 1'b0;
        stk.delete();
        model_step(3'd1, 8'h55, mres, merr, mlat);
        run_op("after abort push", 3'd1, 8'h55, 8'h55, 0, 2, 1);

        // Randomized ops against the queue model
        for (int n = 0; n < 300; n++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd6 && $urandom_range(0, 3) != 0) rop = 3'd1;
            if (n < 150 && $urandom_range(0, 2) == 0) rop = 3'd1;
            rd = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            model_step(rop, rd, mres, merr, mlat);
            run_op($sformatf("rnd%0d op%0d", n, rop), rop, rd, mres, merr, mlat, stk.size());
            if (n % 25 == 0) check_ram($sformatf("rnd%0d", n));
        end
        check_ram("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
